// File: rtl/mfp_uart_receiver.sv
// UART 8N1 receiver: a two-flop input synchronizer, a mid-bit sampling FSM and a
// small output FIFO with a valid/ready handshake and framing/overflow pulses.
module mfp_uart_receiver #(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_error,
  output logic       overflow
);

  localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int TW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CPB / 2 - 1);
  localparam logic [TW-1:0] FULL_RELOAD = TW'(CPB - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          r_rx_meta, r_rx_s;
  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_armed, w_armed_nxt;
  logic          r_framing_error, r_overflow;
  logic          w_push, w_frame_err, w_timer_zero;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_pop, w_wr_en;

  assign w_timer_zero = (r_timer == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rx_meta       <= 1'b1;
      r_rx_s          <= 1'b1;
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      r_armed         <= 1'b0;
      r_framing_error <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      r_rx_meta       <= UART_RX;
      r_rx_s          <= r_rx_meta;
      r_state         <= w_state_nxt;
      r_timer         <= w_timer_nxt;
      r_idx           <= w_idx_nxt;
      r_shift         <= w_shift_nxt;
      r_armed         <= w_armed_nxt;
      r_framing_error <= w_frame_err;
      r_overflow      <= w_push & w_full & ~w_pop;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer - TW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_armed_nxt = r_armed;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = r_timer;
        // A start edge only counts once the line has been seen idle-high.
        if (r_rx_s) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_state_nxt = S_START;
          w_timer_nxt = HALF_RELOAD;
        end
      end
      S_START: begin
        if (w_timer_zero) begin
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_timer_nxt = FULL_RELOAD;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_timer_zero) begin
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_timer_nxt = FULL_RELOAD;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (w_timer_zero) begin
          w_state_nxt = S_IDLE;
          if (r_rx_s) begin
            w_push = 1'b1;
          end else begin
            w_frame_err = 1'b1;
            w_armed_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = rx_valid & rx_ready;
  assign w_wr_en  = w_push & (~w_full | w_pop);
  assign rx_valid = ~w_empty;
  assign rx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; rx_data is masked while empty, so
  // stale contents are never observable.
  always_ff @(posedge HCLK) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  assign framing_error = r_framing_error;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_mfp_uart_receiver.sv
// Scoreboard bench for mfp_uart_receiver at 434 cycles/bit with a 4-entry FIFO.
`timescale 1ns/1ps
module tb_mfp_uart_receiver;

  localparam int CPB = 50_000_000 / 115_200;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       UART_RX = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, framing_error, overflow;

  int         n_vec = 0;
  int         n_err = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         valid_cycles = 0;
  int         fe0, ov0;
  logic [7:0] sb [$];

  mfp_uart_receiver #(
    .CLOCK_FREQUENCY(50_000_000),
    .BAUD_RATE(115_200),
    .FIFO_DEPTH(4)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .UART_RX(UART_RX),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .framing_error(framing_error),
    .overflow(overflow)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame starts one step after the first posedge seen here; each bit lasts CPB cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge HCLK); #1;
    for (int i = 0; i < 10; i++) begin
      UART_RX = bits[i];
      repeat (CPB) @(posedge HCLK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic drain(input string tag);
    rx_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge HCLK);
    idle(3);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_valid_low"}, rx_valid, 1'b0);
    check({tag, "_data_zero"}, rx_data, 8'h00);
  endtask

  // Monitor: pops the scoreboard on every accepted byte and counts pulses.
  always @(negedge HCLK) begin
    if (framing_error) fe_cnt++;
    if (overflow) ov_cnt++;
    if (rx_valid) valid_cycles++;
    if (rx_valid && rx_ready)
      check("pop_data", {1'b0, rx_data},
            (sb.size() != 0) ? {1'b0, sb.pop_front()} : 9'h100);
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    idle(5);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_fe", framing_error, 1'b0);
    check("rst_ov", overflow, 1'b0);
    HRESETn = 1'b1;
    idle(10);

    // 1: single byte with the consumer ready.
    rx_ready = 1'b1;
    valid_cycles = 0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_no_fe", fe_cnt - fe0, 0);
    check("t1_no_ov", ov_cnt - ov0, 0);

    // 2: short low glitch is rejected, then a normal byte.
    valid_cycles = 0;
    fe0 = fe_cnt;
    UART_RX = 1'b0;
    idle(100);
    UART_RX = 1'b1;
    idle(600);
    check("t2_no_valid", valid_cycles, 0);
    check("t2_no_fe", fe_cnt - fe0, 0);
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("t2_sb_empty", sb.size(), 0);

    // 3: stop bit low, then a line-high recovery and a good byte.
    fe0 = fe_cnt;
    valid_cycles = 0;
    send_frame(8'h81, 1'b0);
    idle(200);
    UART_RX = 1'b1;
    idle(50);
    check("t3_fe_pulse", fe_cnt - fe0, 1);
    check("t3_no_valid", valid_cycles, 0);
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(20);
    check("t3_sb_empty", sb.size(), 0);

    // 4: consumer stalled, fifth byte overflows.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int b = 1; b <= 4; b++) sb.push_back(8'(b));
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    idle(20);
    check("t4_valid", rx_valid, 1'b1);
    check("t4_head", rx_data, 8'h01);
    check("t4_ov_pulse", ov_cnt - ov0, 1);
    drain("t4");

    // 5: pop in the very cycle the fifth byte is pushed into a full FIFO.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int b = 1; b <= 5; b++) sb.push_back(8'(b));
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (4126) @(posedge HCLK);
        #1 rx_ready = 1'b1;
        @(posedge HCLK);
        #1 rx_ready = 1'b0;
      end
    join
    idle(20);
    check("t5_no_ov", ov_cnt - ov0, 0);
    check("t5_valid", rx_valid, 1'b1);
    check("t5_head", rx_data, 8'h02);
    drain("t5");

    // 6: reset during bit 4 of 0xF0, then 0x0F.
    rx_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (2271) @(posedge HCLK);
        #1 HRESETn = 1'b0;
        idle(3);
        check("t6_rst_valid", rx_valid, 1'b0);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_fe", framing_error, 1'b0);
        check("t6_rst_ov", overflow, 1'b0);
        idle(15);
        HRESETn = 1'b1;
      end
    join
    idle(50);
    check("t6_partial_dropped", rx_valid, 1'b0);
    sb.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(20);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_no_fe", fe_cnt - fe0, 0);
    check("t6_no_ov", ov_cnt - ov0, 0);
    check("total_fe", fe_cnt, 1);
    check("total_ov", ov_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
